// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised video timing generator and pixel pipeline. Divides
//            the system clock into a pixel strobe, walks the horizontal and
//            vertical counters, requests pixels from a frame source and
//            realigns the returned colour data with the delayed syncs.
// Ports    : clk, rst            - system clock, synchronous active-high reset
//            enable              - run enable; low clears the timing state
//            pix_req/pix_x/pix_y - one-clk pixel request with its coordinate
//            pix_in              - {R,G,B} returned PIX_LAT strobes later
//            hsync/vsync         - syncs with configurable active level
//            rdata/gdata/bdata   - colour outputs, zero outside active area
//            frame_start/vblank  - strobes toward the interrupt logic
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CDEPTH   = 4,
  parameter int CLK_DIV  = 4,
  parameter int PIX_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  pix_req,
  output logic [10:0]           pix_x,
  output logic [9:0]            pix_y,
  input  logic [3*CDEPTH-1:0]   pix_in,
  output logic                  hsync,
  output logic                  vsync,
  output logic [CDEPTH-1:0]     rdata,
  output logic [CDEPTH-1:0]     gdata,
  output logic [CDEPTH-1:0]     bdata,
  output logic                  frame_start,
  output logic                  vblank
);

  localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_h_last   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [9:0]  c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0]  c_vs_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Inactive sync levels; the delayed raw sync is XORed with these.
  localparam logic c_hs_idle = (HS_POL == 0);
  localparam logic c_vs_idle = (VS_POL == 0);

  logic [c_div_w-1:0] r_div;
  logic [10:0]        r_hcnt;
  logic [9:0]         r_vcnt;
  logic [PIX_LAT-1:0] r_de_sr;
  logic [PIX_LAT-1:0] r_hs_sr;
  logic [PIX_LAT-1:0] r_vs_sr;

  logic w_clear;
  logic w_pe;
  logic w_de_raw;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_de_dly;
  logic w_hs_dly;
  logic w_vs_dly;

  // rst and a low enable share one path so a mid-frame stop never leaves a
  // partial line behind; the divider sits at 0 while cleared, so the very
  // first clock after release is a pixel strobe.
  assign w_clear  = rst || !enable;
  assign w_pe     = enable && (r_div == '0);

  assign w_de_raw = (r_hcnt < c_h_active) && (r_vcnt < c_v_active);
  assign w_hs_raw = (r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end);
  assign w_vs_raw = (r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end);

  // Oldest stage carries timing from the strobe whose pixel data is now
  // on pix_in.
  assign w_de_dly = r_de_sr[PIX_LAT-1];
  assign w_hs_dly = r_hs_sr[PIX_LAT-1];
  assign w_vs_dly = r_vs_sr[PIX_LAT-1];

  // Pixel strobe divider.
  always_ff @(posedge clk) begin
    if (w_clear || (r_div == c_div_last)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Frame position counters and the alignment shift registers.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_de_sr <= '0;
      r_hs_sr <= '0;
      r_vs_sr <= '0;
    end else if (w_pe) begin
      if (r_hcnt == c_h_last) begin
        r_hcnt <= '0;
        if (r_vcnt == c_v_last) begin
          r_vcnt <= '0;
        end else begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      r_de_sr[0] <= w_de_raw;
      r_hs_sr[0] <= w_hs_raw;
      r_vs_sr[0] <= w_vs_raw;
      for (int i = 1; i < PIX_LAT; i++) begin
        r_de_sr[i] <= r_de_sr[i-1];
        r_hs_sr[i] <= r_hs_sr[i-1];
        r_vs_sr[i] <= r_vs_sr[i-1];
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= c_hs_idle;
      vsync       <= c_vs_idle;
      rdata       <= '0;
      gdata       <= '0;
      bdata       <= '0;
    end else begin
      pix_req     <= w_pe && w_de_raw;
      frame_start <= w_pe && (r_hcnt == '0) && (r_vcnt == '0);
      vblank      <= (r_vcnt >= c_v_active);
      // Coordinates hold between requests so the source can latch lazily.
      if (w_pe && w_de_raw) begin
        pix_x <= r_hcnt;
        pix_y <= r_vcnt;
      end
      if (w_pe) begin
        hsync <= w_hs_dly ^ c_hs_idle;
        vsync <= w_vs_dly ^ c_vs_idle;
        if (w_de_dly) begin
          rdata <= pix_in[3*CDEPTH-1 -: CDEPTH];
          gdata <= pix_in[2*CDEPTH-1 -: CDEPTH];
          bdata <= pix_in[CDEPTH-1:0];
        end else begin
          rdata <= '0;
          gdata <= '0;
          bdata <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire
